seq_divider: RTL
================

# seq_divider

Sequential unsigned restoring divider: the inverse of the lab's registered 8x8 multiplier. It takes a dividend and a divisor and produces an 8-bit quotient and an 8-bit remainder, resolving one quotient bit per clock. It sits between the switch inputs and the seven-segment digit decoders. It uses a start/busy/done handshake so a top level can drive it from a pushbutton-derived pulse.

## Interface
- N, 8, operand/result width; iteration count equals N
- Clock  input  1  rising-edge system clock; the only clock
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  request; sampled only in IDLE
- A  input  N  dividend, captured when Start is accepted
- B  input  N  divisor, captured when Start is accepted
- Q  output  N  quotient, registered
- R  output  N  remainder, registered
- Busy  output  1  high from acceptance until Done deasserts
- Done  output  1  single-cycle pulse; Q/R valid from this cycle on
- DivZero  output  1  registered flag; high when the last result came from B==0

## Operation
- States: IDLE, RUN, DONE.
- IDLE: Start=1 at a rising edge does the following.
  - Latches A into the dividend shift register and B into the divisor register.
  - Clears the N+1-bit partial remainder.
  - Loads iteration counter = N-1.
  - Moves to RUN.
  - Start=0 keeps the FSM in IDLE.
- RUN: each edge performs the following.
  - Shift {rem, dvd} left by 1.
  - Form trial = rem − {0,divisor} at N+1 bits.
  - If trial is non-negative (MSB 0), rem ← trial and quotient bit ← 1. Otherwise rem is unchanged and quotient bit ← 0.
  - Quotient bits shift into dvd's LSB.
  - After the edge that processes counter==0, go to DONE.
- DONE: Q ← dvd, R ← rem[N-1:0], Done=1 for exactly one cycle, then IDLE.
- Q, R and DivZero hold their values until the next DONE. They are not cleared when a new operation starts.
- All arithmetic is unsigned. R < B always holds for B≠0, and A = Q·B + R.
- B==0 without the feature macro: the algorithm runs unmodified and yields Q = 2^N−1 and R = A.
- Start while Busy (RUN or DONE) is ignored and not queued. Start held high continuously restarts on the first IDLE cycle after DONE.
- A and B may change freely after acceptance. Only the latched copies are used.

## Timing
- Reset (asynchronous, any state, including mid-RUN) forces:
  - state = IDLE
  - Q = 0, R = 0, Busy = 0, Done = 0, DivZero = 0
  - counter = 0, internal registers = 0
- An operation in progress is aborted with no result. Operation resumes on the first edge after Reset falls.
- Start accepted at edge 0: Busy=1 after edge 0, RUN iterations occur at edges 1..N, and DONE is entered after edge N.
  - Done=1 and Q/R are valid during the cycle after edge N.
  - Done=0 and Busy=0 after edge N+1.
  - Total: N+1 edges from acceptance to Done (9 for N=8). The next Start can be accepted at edge N+2 at the earliest.
- Busy and Done are both high during the DONE cycle.
- All outputs are registered. No combinational path runs from any input to any output.

## Configuration
- DIV_ZERO_TRAP_EN defined:
  - When B==0 at acceptance, the FSM goes IDLE→DONE directly (RUN is skipped).
  - Q = 2^N−1, R = A, DivZero = 1. Done occurs one cycle after acceptance.
  - Any result with B≠0 clears DivZero to 0 at its DONE.
- DIV_ZERO_TRAP_EN undefined:
  - The trap logic is absent and DivZero is tied to 0.
  - B==0 takes the normal N+1 latency with the same Q/R values.

## Test plan
- Reset, then A=200, B=7, Start pulse → Done exactly 9 edges later; Q=28, R=4; Busy falls one edge after Done.
- A=255, B=1 → Q=255, R=0. Then A=5, B=9 → Q=0, R=5; Q/R hold between operations.
- A=100, B=0 → Q=255, R=100.
  - Macro defined: Done 1 edge after acceptance, DivZero=1.
  - Macro undefined: Done 9 edges after acceptance, DivZero=0.
  - A following A=9, B=3 operation clears DivZero with Q=3, R=0.
- Start A=200, B=7; pulse Start again with A=1, B=1 at edges 3 and during DONE → both ignored; result Q=28, R=4; exactly one Done pulse.
- Start A=200, B=7; assert Reset asynchronously between edges 4 and 5 → Q, R, Busy, Done and DivZero are 0 immediately. After release, a new A=63, B=8 → Q=7, R=7 with 9-edge latency.
- Sweep all A and all B∈{1..255} against a reference model → A = Q·B + R and R < B for every pair.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional macro DIV_ZERO_TRAP_EN: divide-by-zero short-circuits to DONE and raises div_zero.
module seq_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         busy,
  output logic         done,
  output logic         div_zero
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   dvd_q, dvd_d;
  logic [N-1:0]   dvs_q, dvs_d;
  // The running remainder is always below the divisor, so only the shifted
  // trial value needs the extra bit.
  logic [N-1:0]   rem_q, rem_d;
  logic [N:0]     shifted, trial;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   q_q, q_d, r_q, r_d;
  logic           busy_q, busy_d, done_q, done_d;
`ifdef DIV_ZERO_TRAP_EN
  logic           dz_q, dz_d;
`endif

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
    dz_d    = dz_q;
`endif
    shifted = {rem_q, dvd_q[N-1]};
    trial   = shifted - {1'b0, dvs_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = a;
          dvs_d   = b;
          rem_d   = '0;
          cnt_d   = CW'(N - 1);
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef DIV_ZERO_TRAP_EN
          if (b == '0) begin
            q_d     = '1;
            r_d     = a;
            dz_d    = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      RUN: begin
        rem_d = trial[N] ? shifted[N-1:0] : trial[N-1:0];
        dvd_d = {dvd_q[N-2:0], ~trial[N]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          q_d     = dvd_d;
          r_d     = rem_d;
          done_d  = 1'b1;
          state_d = DONE;
`ifdef DIV_ZERO_TRAP_EN
          dz_d    = 1'b0;
`endif
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DIV_ZERO_TRAP_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef DIV_ZERO_TRAP_EN
  assign div_zero = dz_q;
`else
  assign div_zero = 1'b0;
`endif

endmodule
